// File: rtl/lfsr_gen.sv
// Configurable LFSR with run-time selectable Fibonacci/Galois stepping,
// seed loading with zero-seed substitution, and period measurement.
module lfsr_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             set,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             galois,
  output logic [WIDTH-1:0] out,
  output logic             bit_out,
  output logic             wrap,
  output logic             zero_seed,
  output logic [WIDTH-1:0] period
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             wrap_q, wrap_d;
  logic             zero_q, zero_d;

  logic             fib_fb;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] cnt_inc;

  assign fib_fb    = ^(state_q & TAPS);
  assign fib_next  = {state_q[WIDTH-2:0], fib_fb};
  assign gal_next  = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
  assign step_next = galois ? gal_next : fib_next;

  // Step counter saturates instead of rolling over to keep period meaningful.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    zero_d   = 1'b0;
    if (load) begin
      cnt_d = '0;
      if (seed_in == '0) begin
        state_d = SEED;
        start_d = SEED;
        zero_d  = 1'b1;
      end else begin
        state_d = seed_in;
        start_d = seed_in;
      end
    end else if (en) begin
      state_d = step_next;
      if (step_next == start_q) begin
        wrap_d   = 1'b1;
        period_d = cnt_inc;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      state_q  <= SEED;
      start_q  <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
      zero_q   <= zero_d;
    end
  end

  assign out       = state_q;
  assign bit_out   = galois ? state_q[0] : state_q[WIDTH-1];
  assign wrap      = wrap_q;
  assign zero_seed = zero_q;
  assign period    = period_q;

endmodule
